cop_instr_sequencer: RTL

Program sequencer for the matrix coprocessor. It holds a small program of 22-bit coprocessor instructions, issues them one at a time to the coprocessor's instruction input and waits for completion before fetching the next. It replaces manual per-button instruction stepping, supports free-run and single-step modes, and stops on an end marker, end of memory or a timeout.

---
 rtl/cop_instr_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cop_instr_sequencer.sv
// Program sequencer for the matrix coprocessor: fetches 22-bit instructions from a
// small local program memory, issues them one at a time and waits for completion.
module cop_instr_sequencer #(
   parameter int AW      = 5,
   parameter int IW      = 22,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic          start,
   input  logic          step_mode,
   input  logic          step,
   input  logic          abort,
   input  logic          cop_busy,
   input  logic          cop_done,
   output logic [IW-1:0] instr_out,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          running,
   output logic          halted,
   output logic          err_timeout
);

   localparam int DEPTH = 2 ** AW;
   localparam int CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_PAUSE,
      S_HALT
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [IW-1:0] instr_q, instr_d;
   logic          valid_q, valid_d;
   logic          running_q, running_d;
   logic          halted_q, halted_d;
   logic          err_q, err_d;
   logic          step_q, step_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] rd_q, rd_d;
   logic [IW-1:0] mem_q [0:DEPTH-1];

   logic          step_rise;
   logic          mem_wr;

   // Program memory is only writable while the sequencer is not executing.
   assign mem_wr = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem_q[prog_addr] <= prog_data;
      end
      rd_q <= rd_d;
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = 1'b0;
      err_d     = err_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      step_d    = step;
      step_rise = step && !step_q;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               pc_d    = '0;
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            rd_d = mem_q[pc_q];
            if (abort) begin
               state_d = S_HALT;
            end else begin
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            if (abort) begin
               state_d = S_HALT;
            end else if (rd_q[3:0] == 4'h0) begin
               state_d = S_HALT;
            end else if (!cop_busy) begin
               instr_d = rd_q;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            // abort takes precedence over a coincident cop_done, leaving pc untouched
            if (abort) begin
               state_d = S_HALT;
            end else if (cop_done) begin
               if (pc_q == '1) begin
                  state_d = S_HALT;
               end else begin
                  pc_d    = pc_q + AW'(1);
                  state_d = step_mode ? S_PAUSE : S_FETCH;
               end
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_PAUSE: begin
            if (abort) begin
               state_d = S_HALT;
            end else if (step_rise || !step_mode) begin
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      running_d = !((state_d == S_IDLE) || (state_d == S_HALT));
      halted_d  = (state_d == S_HALT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
         err_q     <= 1'b0;
         step_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         running_q <= running_d;
         halted_q  <= halted_d;
         err_q     <= err_d;
         step_q    <= step_d;
         cnt_q     <= cnt_d;
      end
   end

   assign instr_out   = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign running     = running_q;
   assign halted      = halted_q;
   assign err_timeout = err_q;

endmodule
